// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credit accumulator, programmable price table,
// dispenser handshake, change/refund and idle timeout. Optional stock tracking: VEND_STOCK_EN.
module vend_ctrl_multi #(
    parameter int NPROD     = 4,
    parameter int SW        = 2,
    parameter int CW        = 8,
    parameter int DEF_PRICE = 10,
    parameter int TIMEOUT   = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_valid,
    input  logic [CW-1:0]    coin_val,
    input  logic             sel_valid,
    input  logic [SW-1:0]    sel_id,
    input  logic             cancel,
    input  logic             maint,
    input  logic             price_wr,
    input  logic [CW-1:0]    price_data,
    input  logic             vend_ack,
    output logic             vend_req,
    output logic [SW-1:0]    vend_id,
    output logic             change_valid,
    output logic [CW-1:0]    change_amt,
    output logic [CW-1:0]    credit,
    output logic             coin_reject,
    output logic             sel_err,
`ifdef VEND_STOCK_EN
    output logic [NPROD-1:0] sold_out,
`endif
    output logic [2:0]       state
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CREDIT = 3'd1,
        S_VEND   = 3'd2,
        S_CHANGE = 3'd3,
        S_MAINT  = 3'd4,
        S_REFUND = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic [SW-1:0]   vend_id_q, vend_id_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            vend_req_q, vend_req_d;
    logic            change_valid_q, change_valid_d;
    logic [CW-1:0]   change_amt_q, change_amt_d;
    logic            coin_reject_q, coin_reject_d;
    logic            sel_err_q, sel_err_d;
    logic [CW-1:0]   price_q [NPROD];

    logic            sel_in_range_s;
    logic [CW-1:0]   sel_price_s;
    logic [CW-1:0]   vend_price_s;
    logic [CW:0]     sum_s;
    logic [CW-1:0]   vend_rem_s;
    logic            sel_bad_s;
    logic            price_we_s;
    logic            stock_empty_s;

`ifdef VEND_STOCK_EN
    logic [7:0]      stock_q [NPROD];
    logic [7:0]      stock_d [NPROD];
`endif

    // Operand lookup: selected price, vended price and the widened coin sum.
    always_comb begin
        sel_in_range_s = (32'(sel_id) < NPROD);
        sel_price_s    = {CW{1'b0}};
        vend_price_s   = {CW{1'b0}};
        if (sel_in_range_s) begin
            sel_price_s = price_q[sel_id];
        end else begin
            sel_price_s = {CW{1'b0}};
        end
        if (32'(vend_id_q) < NPROD) begin
            vend_price_s = price_q[vend_id_q];
        end else begin
            vend_price_s = {CW{1'b0}};
        end
        sum_s      = {1'b0, credit_q} + {1'b0, coin_val};
        vend_rem_s = credit_q - vend_price_s;
    end

    // Stock emptiness of the selected product; never empty without stock tracking.
    always_comb begin
        stock_empty_s = 1'b0;
`ifdef VEND_STOCK_EN
        if (sel_in_range_s) begin
            stock_empty_s = (stock_q[sel_id] == 8'd0);
        end else begin
            stock_empty_s = 1'b1;
        end
`endif
    end

    assign sel_bad_s  = !sel_in_range_s || (sel_price_s == {CW{1'b0}}) ||
                        (credit_q < sel_price_s) || stock_empty_s;
    assign price_we_s = (state_q == S_MAINT) && price_wr && sel_in_range_s;

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        vend_id_d      = vend_id_q;
        tmr_d          = tmr_q;
        coin_reject_d  = 1'b0;
        sel_err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmr_d = {TW{1'b0}};
                if (maint) begin
                    state_d = S_MAINT;
                end else if (coin_valid) begin
                    credit_d = coin_val;
                    state_d  = S_CREDIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CREDIT: begin
                // A coin in the same cycle as a select wins; the select is dropped.
                if (cancel) begin
                    state_d = S_REFUND;
                end else if (coin_valid) begin
                    tmr_d = {TW{1'b0}};
                    if (sum_s[CW]) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = sum_s[CW-1:0];
                    end
                end else if (sel_valid) begin
                    tmr_d = {TW{1'b0}};
                    if (sel_bad_s) begin
                        sel_err_d = 1'b1;
                    end else begin
                        vend_id_d = sel_id;
                        state_d   = S_VEND;
                    end
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_REFUND;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_VEND: begin
                coin_reject_d = coin_valid;
                if (vend_ack) begin
                    credit_d = vend_rem_s;
                    if (vend_rem_s != {CW{1'b0}}) begin
                        state_d = S_CHANGE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_VEND;
                end
            end
            S_CHANGE, S_REFUND: begin
                credit_d = {CW{1'b0}};
                state_d  = S_IDLE;
            end
            S_MAINT: begin
                coin_reject_d = coin_valid;
                if (!maint) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_MAINT;
                end
            end
            default: begin
                credit_d = {CW{1'b0}};
                state_d  = S_IDLE;
            end
        endcase
        vend_req_d     = (state_d == S_VEND);
        change_valid_d = (state_d == S_CHANGE) || (state_d == S_REFUND);
        if (change_valid_d) begin
            change_amt_d = credit_d;
        end else begin
            change_amt_d = {CW{1'b0}};
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            credit_q       <= {CW{1'b0}};
            vend_id_q      <= {SW{1'b0}};
            tmr_q          <= {TW{1'b0}};
            vend_req_q     <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= {CW{1'b0}};
            coin_reject_q  <= 1'b0;
            sel_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_id_q      <= vend_id_d;
            tmr_q          <= tmr_d;
            vend_req_q     <= vend_req_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
            sel_err_q      <= sel_err_d;
        end
    end

    // Price table, writable only in maintenance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPROD; i++) begin
                price_q[i] <= CW'(DEF_PRICE);
            end
        end else if (price_we_s) begin
            price_q[sel_id] <= price_data;
        end else begin
            price_q <= price_q;
        end
    end

`ifdef VEND_STOCK_EN
    // Stock next-state: maintenance load, saturating decrement on dispense.
    always_comb begin
        stock_d = stock_q;
        if (price_we_s) begin
            stock_d[sel_id] = price_data[7:0];
        end else if ((state_q == S_VEND) && vend_ack && (stock_q[vend_id_q] != 8'd0)) begin
            stock_d[vend_id_q] = stock_q[vend_id_q] - 8'd1;
        end else begin
            stock_d = stock_q;
        end
    end

    // Stock registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPROD; i++) begin
                stock_q[i] <= 8'd0;
            end
        end else begin
            stock_q <= stock_d;
        end
    end

    for (genvar g = 0; g < NPROD; g++) begin : g_sold
        assign sold_out[g] = (stock_q[g] == 8'd0);
    end
`endif

    assign state        = state_q;
    assign credit       = credit_q;
    assign vend_id      = vend_id_q;
    assign vend_req     = vend_req_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign coin_reject  = coin_reject_q;
    assign sel_err      = sel_err_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed self-checking bench for vend_ctrl_multi (NPROD=4, CW=8, TIMEOUT=8).
module tb_vend_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_val = 8'd0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'd0;
    logic       cancel = 1'b0;
    logic       maint = 1'b0;
    logic       price_wr = 1'b0;
    logic [7:0] price_data = 8'd0;
    logic       vend_ack = 1'b0;
    logic       vend_req;
    logic [1:0] vend_id;
    logic       change_valid;
    logic [7:0] change_amt;
    logic [7:0] credit;
    logic       coin_reject;
    logic       sel_err;
    logic [2:0] state;
`ifdef VEND_STOCK_EN
    logic [3:0] sold_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vend_ctrl_multi #(
        .NPROD(4), .SW(2), .CW(8), .DEF_PRICE(10), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .maint(maint),
        .price_wr(price_wr), .price_data(price_data), .vend_ack(vend_ack),
        .vend_req(vend_req), .vend_id(vend_id), .change_valid(change_valid),
        .change_amt(change_amt), .credit(credit), .coin_reject(coin_reject),
        .sel_err(sel_err),
`ifdef VEND_STOCK_EN
        .sold_out(sold_out),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
        price_wr = 1'b0; vend_ack = 1'b0;
    endtask

    task automatic coin(input logic [7:0] v);
        coin_valid = 1'b1; coin_val = v;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic sel(input logic [1:0] id);
        sel_valid = 1'b1; sel_id = id;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic pwrite(input logic [1:0] id, input logic [7:0] d);
        price_wr = 1'b1; sel_id = id; price_data = d;
        tick();
        price_wr = 1'b0;
    endtask

    // With stock tracking, everything starts sold out; give each product stock 10 at price 10.
    task automatic prime_stock();
`ifdef VEND_STOCK_EN
        maint = 1'b1; tick();
        for (int i = 0; i < 4; i++) pwrite(2'(i), 8'd10);
        maint = 1'b0; tick();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        tick(); tick();
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_credit", 32'(credit), 32'd0);
        check_eq("rst_vend_req", 32'(vend_req), 32'd0);
        check_eq("rst_change_valid", 32'(change_valid), 32'd0);
        rst = 1'b1;
        tick();
        prime_stock();

        // Basic purchase with change
        coin(8'd5);
        check_eq("t1_state_credit", 32'(state), 32'd1);
        check_eq("t1_credit5", 32'(credit), 32'd5);
        coin(8'd5); coin(8'd5);
        check_eq("t1_credit15", 32'(credit), 32'd15);
        sel(2'd1);
        check_eq("t1_state_vend", 32'(state), 32'd2);
        check_eq("t1_vend_req", 32'(vend_req), 32'd1);
        check_eq("t1_vend_id", 32'(vend_id), 32'd1);
        tick(); tick();
        check_eq("t1_vend_req_hold", 32'(vend_req), 32'd1);
        vend_ack = 1'b1; tick(); vend_ack = 1'b0;
        check_eq("t1_change_valid", 32'(change_valid), 32'd1);
        check_eq("t1_change_amt", 32'(change_amt), 32'd5);
        check_eq("t1_vend_req_drop", 32'(vend_req), 32'd0);
        check_eq("t1_state_change", 32'(state), 32'd3);
        tick();
        check_eq("t1_state_idle", 32'(state), 32'd0);
        check_eq("t1_credit0", 32'(credit), 32'd0);
        check_eq("t1_change_off", 32'(change_valid), 32'd0);
        check_eq("t1_amt_off", 32'(change_amt), 32'd0);

        // Overflowing coin is refused, then cancel refunds everything
        coin(8'd250);
        coin(8'd10);
        check_eq("t2_coin_reject", 32'(coin_reject), 32'd1);
        check_eq("t2_credit_hold", 32'(credit), 32'd250);
        tick();
        check_eq("t2_reject_pulse", 32'(coin_reject), 32'd0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        check_eq("t2_state_refund", 32'(state), 32'd5);
        check_eq("t2_change_valid", 32'(change_valid), 32'd1);
        check_eq("t2_change_amt", 32'(change_amt), 32'd250);
        tick();
        check_eq("t2_state_idle", 32'(state), 32'd0);
        check_eq("t2_credit0", 32'(credit), 32'd0);

        // Maintenance price programming and select refusals
        maint = 1'b1; tick();
        check_eq("t3_state_maint", 32'(state), 32'd4);
        coin(8'd5);
        check_eq("t3_maint_reject", 32'(coin_reject), 32'd1);
        pwrite(2'd2, 8'd0);
        pwrite(2'd3, 8'd30);
        maint = 1'b0; tick();
        check_eq("t3_state_idle", 32'(state), 32'd0);
        coin(8'd20);
        sel(2'd2);
        check_eq("t3_sel_err_disabled", 32'(sel_err), 32'd1);
        check_eq("t3_stay_credit", 32'(state), 32'd1);
        sel(2'd3);
        check_eq("t3_sel_err_short", 32'(sel_err), 32'd1);
        coin(8'd10);
        check_eq("t3_credit30", 32'(credit), 32'd30);
        check_eq("t3_sel_err_clear", 32'(sel_err), 32'd0);
        sel(2'd3);
        check_eq("t3_vend_id3", 32'(vend_id), 32'd3);
        vend_ack = 1'b1; tick(); vend_ack = 1'b0;
        check_eq("t3_no_change", 32'(change_valid), 32'd0);
        check_eq("t3_state_idle2", 32'(state), 32'd0);
        check_eq("t3_credit0", 32'(credit), 32'd0);

        // Inactivity timeout
        coin(8'd7);
        for (int i = 0; i < 7; i++) tick();
        check_eq("t4_still_credit", 32'(state), 32'd1);
        tick();
        check_eq("t4_state_refund", 32'(state), 32'd5);
        check_eq("t4_change_amt", 32'(change_amt), 32'd7);
        tick();
        check_eq("t4_state_idle", 32'(state), 32'd0);

        // Reset during vend
        coin(8'd10);
        sel(2'd0);
        check_eq("t5_vend_req", 32'(vend_req), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("t5_async_vend_req", 32'(vend_req), 32'd0);
        check_eq("t5_async_credit", 32'(credit), 32'd0);
        check_eq("t5_async_state", 32'(state), 32'd0);
        check_eq("t5_no_refund", 32'(change_valid), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        prime_stock();
        coin(8'd5);
        sel(2'd3);
        check_eq("t5_def_price_err", 32'(sel_err), 32'd1);
        coin(8'd5);
        sel(2'd3);
        check_eq("t5_def_price_vend", 32'(state), 32'd2);
        vend_ack = 1'b1; tick(); vend_ack = 1'b0;
        check_eq("t5_idle", 32'(state), 32'd0);

`ifdef VEND_STOCK_EN
        // Stock exhaustion
        maint = 1'b1; tick();
        pwrite(2'd0, 8'd1);
        maint = 1'b0; tick();
        check_eq("t6_in_stock", 32'(sold_out[0]), 32'd0);
        coin(8'd1);
        sel(2'd0);
        check_eq("t6_vend", 32'(state), 32'd2);
        vend_ack = 1'b1; tick(); vend_ack = 1'b0;
        check_eq("t6_sold_out", 32'(sold_out[0]), 32'd1);
        coin(8'd1);
        sel(2'd0);
        check_eq("t6_sel_err", 32'(sel_err), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised next-generation vending controller for NPROD products. Combines a credit accumulator, a run-time programmable price table, a vend handshake to the dispenser, change/refund output and an inactivity timeout.
Sits between the coin acceptor / keypad front end and the dispenser datapath.
It generalises the fixed single-product control unit with these additions:
- product indexing;
- in-block arithmetic;
- a timeout counter.

Parameters:
NPROD, 4, number of products (2..16)
SW, 2, product index width; NPROD <= 2**SW
CW, 8, credit and price width in currency units
DEF_PRICE, 10, reset value of every price entry
TIMEOUT, 1000, idle cycles in S_CREDIT before auto-refund (>=2)

Ports:
clk  in  1  clock, rising-edge active
rst  in  1  reset, asynchronous, active-low
coin_valid  in  1  one-cycle coin-accepted strobe
coin_val  in  CW  value of coin, sampled with coin_valid
sel_valid  in  1  one-cycle product-select strobe
sel_id  in  SW  product index for select or price write
cancel  in  1  refund request
maint  in  1  maintenance mode level
price_wr  in  1  price write strobe (maintenance only)
price_data  in  CW  price written to entry sel_id
vend_ack  in  1  dispenser done
vend_req  out  1  dispense request
vend_id  out  SW  product to dispense
change_valid  out  1  one-cycle change/refund strobe
change_amt  out  CW  change/refund amount
credit  out  CW  current credit
coin_reject  out  1  one-cycle: coin refused
sel_err  out  1  one-cycle: select refused
state  out  3  current state code

Behaviour:
- Reset values:
  - All outputs 0.
  - state = S_IDLE.
  - Every price = DEF_PRICE.
  - Timeout counter 0.
- States:
  - S_IDLE=0, S_CREDIT=1, S_VEND=2, S_CHANGE=3, S_MAINT=4, S_REFUND=5.
  - Codes 6 and 7 return to S_IDLE on the next edge.
- S_IDLE:
  - maint high -> S_MAINT. maint has highest priority.
  - Else, coin_valid -> credit = coin_val, then S_CREDIT.
  - Select or cancel is ignored here.
- S_CREDIT, per-cycle priority is cancel > coin > select:
  - cancel -> S_REFUND.
  - coin_valid:
    - If credit+coin_val > 2**CW-1, pulse coin_reject next cycle; credit unchanged.
    - Else credit += coin_val.
    - In both cases the timeout counter is cleared.
  - sel_valid with price[sel_id]==0, or sel_id>=NPROD, or credit < price -> sel_err pulse; stay.
  - Otherwise latch vend_id = sel_id -> S_VEND.
  - A coin and a select in the same cycle: the coin is processed and the select is dropped.
  - Timeout counter increments on every cycle with no coin/select. Reaching TIMEOUT-1 -> S_REFUND.
- S_VEND:
  - vend_req = 1; vend_id held stable.
  - Coins are rejected (coin_reject pulse); cancel is ignored.
  - On vend_ack: credit -= price[vend_id]; vend_req drops next cycle.
  - Then credit != 0 -> S_CHANGE, else S_IDLE.
  - No timeout applies in this state.
- S_CHANGE / S_REFUND (one cycle each):
  - change_valid = 1 and change_amt = credit.
  - credit cleared; next state S_IDLE.
- S_MAINT:
  - price_wr writes price[sel_id] = price_data. Writes with sel_id >= NPROD are ignored.
  - Price 0 disables the product.
  - maint low -> S_IDLE.
  - Coins are rejected; select is ignored.
- Price write latency: the new price is visible to a select one cycle after the write.
- Reset mid-operation:
  - Credit is lost, with no refund pulse.
  - vend_req drops asynchronously.
  - The price table returns to DEF_PRICE.
- vend_ack outside S_VEND is ignored.
- change_amt is 0 whenever change_valid is 0.

Optional Feature:
VEND_STOCK_EN
- Defined:
  - Adds a per-product stock counter, 8 bits, reset value 0.
  - In S_MAINT, price_wr also loads stock[sel_id] = price_data[7:0].
  - Selecting a product with stock 0 gives a sel_err pulse.
  - vend_ack decrements the stock of vend_id. The counter saturates at 0.
  - Adds output sold_out [NPROD-1:0], where bit i = (stock[i]==0).
- Undefined: no stock logic, no sold_out port; products never sell out.

Test Plan:
- Reset, then coins 5,5,5, select id 1 (price 10), vend_ack after 3 cycles -> vend_req=1 with vend_id=1; then change_valid pulse with change_amt=5; credit=0; state 0.
- CW=8: credit 250 + coin 10 -> coin_reject pulse, credit stays 250. Then cancel -> change_valid with change_amt=250, then S_IDLE.
- maint=1, price_wr id 2 data 0 and id 3 data 30; maint=0; coin 20, select 2 -> sel_err; select 3 -> sel_err; coin 10, select 3 -> vend, change 0 (no change pulse).
- TIMEOUT=8: coin 7, then idle -> S_REFUND reached exactly 8 cycles after the coin; change_amt=7.
- rst low during S_VEND with vend_req=1 -> vend_req=0 immediately; credit=0; price read-back via select = DEF_PRICE.
- VEND_STOCK_EN: load stock[0]=1, vend product 0 once -> sold_out[0]=1; second select 0 -> sel_err.
